// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR oversampling sequencer.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } sar_state_e;

  localparam int SAR_WIDTH_DEF = 8;

  // Summing 2^log2_n samples of width bits needs log2_n extra bits of headroom.
  function automatic int sar_acc_width(input int width, input int log2_n);
    return width + log2_n;
  endfunction

endpackage

// File: rtl/sar_edge_det.sv
// Single-bit rising-edge detector: rise is high while din is 1 and was 0 last cycle.
module sar_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/sar_oversampler.sv
// Requests conversions from the SAR controller, averages 2^LOG2_N results and
// hands the mean to the back end over valid/ready; a watchdog aborts stalled bursts.
//
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | go pulse to the controller, watchdog reloaded
//   WAIT  | waiting for a rising edge on adc_valid
//   OUT   | averaged result presented until accepted
module sar_oversampler
  import sar_pkg::*;
#(
  parameter int WIDTH   = SAR_WIDTH_DEF,
  parameter int LOG2_N  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  output logic             go,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_result,
  output logic [WIDTH-1:0] avg_data,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             busy,
  output logic             timeout_err
);

  localparam int ACC_W = sar_acc_width(WIDTH, LOG2_N);
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

  sar_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             go_q, go_d;
  logic             avg_valid_q, avg_valid_d;
  logic [WIDTH-1:0] avg_data_q, avg_data_d;
  logic             busy_q, busy_d;
  logic             timeout_err_q, timeout_err_d;
  logic             adc_rise;
  logic [ACC_W-1:0] acc_sum;

  sar_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .din  (adc_valid),
    .rise (adc_rise)
  );

  assign acc_sum = acc_q + ACC_W'(adc_result);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    wd_d          = wd_q;
    avg_data_d    = avg_data_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = REQ;
          acc_d         = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b0;
        end
      end
      REQ: begin
        state_d = WAIT;
        wd_d    = WD_LOAD;
      end
      WAIT: begin
        // A capture on the last watchdog cycle still counts as an answer.
        if (adc_rise) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d    = OUT;
            avg_data_d = WIDTH'(acc_sum >> LOG2_N);
          end else begin
            state_d = REQ;
          end
        end else if (wd_q == '0) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end
      OUT: begin
        if (avg_ready) begin
          if (cont) begin
            state_d = REQ;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    go_d        = (state_d == REQ);
    avg_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      go_q          <= 1'b0;
      avg_valid_q   <= 1'b0;
      avg_data_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      wd_q          <= wd_d;
      go_q          <= go_d;
      avg_valid_q   <= avg_valid_d;
      avg_data_q    <= avg_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign go          = go_q;
  assign avg_valid   = avg_valid_q;
  assign avg_data    = avg_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sar_oversampler.sv
// Directed bench for sar_oversampler: a controller model answers go after a fixed latency.
module tb_sar_oversampler;

  localparam int LAT = 2;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       rst, start, cont, avg_ready;
  logic       go, avg_valid, busy, timeout_err;
  logic       adc_valid = 1'b0;
  logic [7:0] adc_result = 8'h00;
  logic [7:0] avg_data;

  logic       p_start, p_cont, p_avg_ready;
  logic       p_go, p_avg_valid, p_busy, p_timeout_err;
  logic       p_valid = 1'b0;
  logic [7:0] p_result = 8'h00;
  logic [7:0] p_val = 8'h00;
  logic [7:0] p_avg_data;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_oversampler #(.WIDTH(8), .LOG2_N(2), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .go          (go),
    .adc_valid   (adc_valid),
    .adc_result  (adc_result),
    .avg_data    (avg_data),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  sar_oversampler #(.WIDTH(8), .LOG2_N(0), .TIMEOUT(TO)) dut_pt (
    .clk         (clk),
    .rst         (rst),
    .start       (p_start),
    .cont        (p_cont),
    .go          (p_go),
    .adc_valid   (p_valid),
    .adc_result  (p_result),
    .avg_data    (p_avg_data),
    .avg_valid   (p_avg_valid),
    .avg_ready   (p_avg_ready),
    .busy        (p_busy),
    .timeout_err (p_timeout_err)
  );

  // Controller model: answers go after LAT cycles from a result table.
  logic [7:0] res_tab [8];
  int   cd = 0, go_cnt = 0, idx = 0, resp_limit = 100, last_go_cyc = 0;
  logic level_mode = 1'b0, mdl_clr = 1'b0, av_seen = 1'b0;

  always @(negedge clk) begin
    if (mdl_clr) begin
      cd = 0; go_cnt = 0; idx = 0; adc_valid = 1'b0; av_seen = 1'b0;
    end else begin
      if (avg_valid) av_seen = 1'b1;
      if (!level_mode && adc_valid) adc_valid = 1'b0;
      if (go) begin
        go_cnt++;
        last_go_cyc = cyc;
        if (go_cnt <= resp_limit) cd = LAT;
      end else if (cd > 0) begin
        if (level_mode && cd == LAT) adc_valid = 1'b0;
        cd--;
        if (cd == 0) begin
          adc_valid  = 1'b1;
          adc_result = res_tab[idx];
          idx        = (idx + 1) % 8;
        end
      end
    end
  end

  int p_cd = 0, p_go_cnt = 0;
  always @(negedge clk) begin
    if (p_valid) p_valid = 1'b0;
    if (p_go) begin
      p_go_cnt++;
      p_cd = 1;
    end else if (p_cd > 0) begin
      p_cd--;
      if (p_cd == 0) begin
        p_valid  = 1'b1;
        p_result = p_val;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    res_tab[0] = a; res_tab[1] = b; res_tab[2] = c; res_tab[3] = d;
    res_tab[4] = a; res_tab[5] = b; res_tab[6] = c; res_tab[7] = d;
  endtask

  task automatic model_clear();
    @(posedge clk);
    mdl_clr = 1'b1;
    @(posedge clk);
    mdl_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("go_after_start", 32'(go), 1);
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_valid(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = avg_valid;
    end
  endtask

  task automatic run_avg(input string tag, input logic [7:0] exp);
    logic seen;
    do_start();
    wait_valid(200, seen);
    chk({tag, "_seen"}, 32'(seen), 1);
    chk({tag, "_data"}, 32'(avg_data), 32'(exp));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(avg_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    logic       seen;
    logic [7:0] d0, o0, o1;
    int         stable, n_out;

    rst = 1'b1; start = 1'b0; cont = 1'b0; avg_ready = 1'b1;
    p_start = 1'b0; p_cont = 1'b0; p_avg_ready = 1'b1;
    fill(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_go", 32'(go), 0);
    chk("rst_avg_valid", 32'(avg_valid), 0);
    chk("rst_avg_data", 32'(avg_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(8'h46, 8'h46, 8'h46, 8'h46);
    model_clear();
    run_avg("const46", 8'h46);
    chk("const46_gos", go_cnt, 4);

    fill(8'd10, 8'd11, 8'd12, 8'd13);
    model_clear();
    run_avg("seq10", 8'h0B);

    fill(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    model_clear();
    run_avg("max255", 8'hFF);

    // Back end stalls for 20 cycles.
    fill(8'h20, 8'h21, 8'h22, 8'h23);
    model_clear();
    avg_ready = 1'b0;
    do_start();
    wait_valid(200, seen);
    chk("stall_seen", 32'(seen), 1);
    d0 = avg_data;
    chk("stall_data", 32'(d0), 32'h21);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avg_valid && avg_data == d0) stable++;
    end
    chk("stall_stable", stable, 20);
    chk("stall_gos", go_cnt, 4);
    avg_ready = 1'b1;
    @(negedge clk);
    chk("stall_valid_drop", 32'(avg_valid), 0);
    chk("stall_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("stall_no_extra_go", go_cnt, 4);

    // Controller goes silent after the second request.
    fill(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    model_clear();
    resp_limit = 2;
    do_start();
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = timeout_err;
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_latency", cyc - last_go_cyc, TO + 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_no_output", 32'(av_seen), 0);
    chk("to_gos", go_cnt, 3);
    resp_limit = 100;
    do_start();
    chk("to_cleared_by_start", 32'(timeout_err), 0);
    wait_valid(200, seen);
    chk("to_recover_data", 32'(avg_data), 32'h5A);
    @(negedge clk);

    // Reset in WAIT after two captures; the next burst must see only fresh samples.
    fill(8'hF0, 8'hF0, 8'hF0, 8'hF0);
    model_clear();
    do_start();
    for (int i = 0; i < 100 && go_cnt < 3; i++) @(negedge clk);
    chk("rm_reach_third", 32'(go_cnt >= 3), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_go", 32'(go), 0);
    chk("rm_avg_valid", 32'(avg_valid), 0);
    chk("rm_avg_data", 32'(avg_data), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_timeout_err", 32'(timeout_err), 0);
    rst = 1'b0;
    fill(8'd4, 8'd8, 8'd12, 8'd16);
    model_clear();
    run_avg("rm_fresh", 8'h0A);

    // Continuous mode with adc_valid held as a level into the next WAIT.
    res_tab[0] = 8'h10; res_tab[1] = 8'h12; res_tab[2] = 8'h14; res_tab[3] = 8'h16;
    res_tab[4] = 8'h30; res_tab[5] = 8'h30; res_tab[6] = 8'h31; res_tab[7] = 8'h31;
    model_clear();
    level_mode = 1'b1;
    cont = 1'b1;
    do_start();
    n_out = 0; o0 = 8'h00; o1 = 8'h00;
    for (int i = 0; i < 300 && n_out < 2; i++) begin
      @(negedge clk);
      if (avg_valid) begin
        if (n_out == 0) o0 = avg_data;
        else            o1 = avg_data;
        n_out++;
        if (n_out == 2) cont = 1'b0;
      end
    end
    chk("cont_outputs", n_out, 2);
    chk("cont_avg0", 32'(o0), 32'h13);
    chk("cont_avg1", 32'(o1), 32'h30);
    @(negedge clk);
    chk("cont_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("cont_gos", go_cnt, 8);
    level_mode = 1'b0;
    model_clear();

    // Pass-through build.
    foreach (res_tab[i]) res_tab[i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      p_val = (k == 0) ? 8'h00 : (k == 1) ? 8'h7F : 8'hA5;
      p_start = 1'b1;
      @(negedge clk);
      p_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = p_avg_valid;
      end
      chk("pt_seen", 32'(seen), 1);
      chk("pt_data", 32'(p_avg_data), 32'(p_val));
      @(negedge clk);
      chk("pt_idle", 32'(p_busy), 0);
    end
    chk("pt_gos", p_go_cnt, 3);
    chk("pt_no_timeout", 32'(p_timeout_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
